// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: memory-wait stalls with timeout, redirect and load-use
// handling, EX operand forwarding select and a saturating stall-cycle counter.
module hazard_controller #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       readAddress1_ID,
  input  logic [4:0]       readAddress2_ID,
  input  logic [4:0]       readAddress1_EX,
  input  logic [4:0]       readAddress2_EX,
  input  logic [4:0]       writeAddress_EX,
  input  logic [4:0]       writeAddress_MEM,
  input  logic [4:0]       writeAddress_WB,
  input  logic             regWrite_MEM,
  input  logic             regWrite_WB,
  input  logic [1:0]       resultSrc_EX,
  input  logic             PCSrc_EX,
  input  logic             memAccess_MEM,
  input  logic             memAck,
  output logic             memReq,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             stall_EX,
  output logic             stall_MEM,
  output logic             flush_ID,
  output logic             flush_EX,
  output logic             flush_WB,
  output logic [1:0]       forwardA_EX,
  output logic [1:0]       forwardB_EX,
  output logic             memError,
  output logic [CNT_W-1:0] stallCycles
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERROR    = 2'b10
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [15:0]      r_wait_cnt;
  logic             r_mem_error;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             w_mem_stall;
  logic             w_load_use;

  // MEM result beats WB result; x0 is hardwired zero and never forwarded
  function automatic logic [1:0] fwd_sel(
    input logic       rw_mem,
    input logic [4:0] wa_mem,
    input logic       rw_wb,
    input logic [4:0] wa_wb,
    input logic [4:0] ra
  );
    logic [1:0] sel;
    if (rw_mem && (wa_mem != 5'd0) && (wa_mem == ra)) begin
      sel = 2'b10;
    end else if (rw_wb && (wa_wb != 5'd0) && (wa_wb == ra)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Next-state logic for the memory handshake
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (memAccess_MEM && !memAck) begin
          w_state_next = ST_MEM_WAIT;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (memAck) begin
          w_state_next = ST_RUN;
        end else if (r_wait_cnt == TO_LAST) begin
          w_state_next = ST_ERROR;
        end else begin
          w_state_next = ST_MEM_WAIT;
        end
      end
      ST_ERROR: w_state_next = ST_ERROR;
      default:  w_state_next = ST_ERROR;
    endcase
  end

  // Stall/flush/request outputs; a memory stall overrides redirect and load-use
  always_comb begin
    w_mem_stall = 1'b0;
    memReq      = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_mem_stall = memAccess_MEM && !memAck;
        memReq      = memAccess_MEM;
      end
      ST_MEM_WAIT: begin
        w_mem_stall = !memAck;
        memReq      = 1'b1;
      end
      ST_ERROR: begin
        w_mem_stall = 1'b1;
        memReq      = 1'b0;
      end
      default: begin
        w_mem_stall = 1'b1;
        memReq      = 1'b0;
      end
    endcase

    w_load_use = (resultSrc_EX == 2'b01) && (writeAddress_EX != 5'd0) &&
                 ((writeAddress_EX == readAddress1_ID) || (writeAddress_EX == readAddress2_ID));

    stall_IF  = 1'b0;
    stall_ID  = 1'b0;
    stall_EX  = 1'b0;
    stall_MEM = 1'b0;
    flush_ID  = 1'b0;
    flush_EX  = 1'b0;
    flush_WB  = 1'b0;
    if (w_mem_stall) begin
      stall_IF  = 1'b1;
      stall_ID  = 1'b1;
      stall_EX  = 1'b1;
      stall_MEM = 1'b1;
      flush_WB  = 1'b1;
    end else if (PCSrc_EX) begin
      flush_ID = 1'b1;
      flush_EX = 1'b1;
    end else if (w_load_use) begin
      stall_IF = 1'b1;
      stall_ID = 1'b1;
      flush_EX = 1'b1;
    end else begin
      flush_EX = 1'b0;
    end

    forwardA_EX = fwd_sel(regWrite_MEM, writeAddress_MEM, regWrite_WB, writeAddress_WB,
                          readAddress1_EX);
    forwardB_EX = fwd_sel(regWrite_MEM, writeAddress_MEM, regWrite_WB, writeAddress_WB,
                          readAddress2_EX);
  end

  // State, wait counter, sticky error and performance counter
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state        <= ST_RUN;
      r_wait_cnt     <= 16'd0;
      r_mem_error    <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state != ST_MEM_WAIT) && (w_state_next == ST_MEM_WAIT)) begin
        r_wait_cnt <= 16'd0;
      end else if (r_state == ST_MEM_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end else begin
        r_wait_cnt <= r_wait_cnt;
      end
      if (w_state_next == ST_ERROR) begin
        r_mem_error <= 1'b1;
      end else begin
        r_mem_error <= r_mem_error;
      end
      if (stall_IF && !(&r_stall_cycles)) begin
        r_stall_cycles <= r_stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_stall_cycles <= r_stall_cycles;
      end
    end
  end

  assign memError    = r_mem_error;
  assign stallCycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_controller.sv
// Randomized plus directed bench for hazard_controller against a behavioural model
// that tracks the memory wait as "waiting / cycles waited / failed".
module tb_hazard_controller;

  localparam int TO  = 4;
  localparam int CW  = 6;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          clr;
  logic [4:0]    ra1_id, ra2_id, ra1_ex, ra2_ex, wa_ex, wa_mem, wa_wb;
  logic          rw_mem, rw_wb, pcsrc, acc, ack;
  logic [1:0]    rsrc;
  logic          mem_req, s_if, s_id, s_ex, s_mem, f_id, f_ex, f_wb, mem_err;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit m_waiting;
  int m_waited;
  bit m_failed;
  int m_stalls;

  hazard_controller #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr),
    .readAddress1_ID(ra1_id), .readAddress2_ID(ra2_id),
    .readAddress1_EX(ra1_ex), .readAddress2_EX(ra2_ex),
    .writeAddress_EX(wa_ex), .writeAddress_MEM(wa_mem), .writeAddress_WB(wa_wb),
    .regWrite_MEM(rw_mem), .regWrite_WB(rw_wb), .resultSrc_EX(rsrc),
    .PCSrc_EX(pcsrc), .memAccess_MEM(acc), .memAck(ack), .memReq(mem_req),
    .stall_IF(s_if), .stall_ID(s_id), .stall_EX(s_ex), .stall_MEM(s_mem),
    .flush_ID(f_id), .flush_EX(f_ex), .flush_WB(f_wb),
    .forwardA_EX(fwd_a), .forwardB_EX(fwd_b),
    .memError(mem_err), .stallCycles(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] ra);
    if (rw_mem && wa_mem != 5'd0 && wa_mem == ra) return 2'b10;
    if (rw_wb && wa_wb != 5'd0 && wa_wb == ra) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle_inputs();
    clr = 1'b0; ra1_id = 5'd0; ra2_id = 5'd0; ra1_ex = 5'd0; ra2_ex = 5'd0;
    wa_ex = 5'd0; wa_mem = 5'd0; wa_wb = 5'd0; rw_mem = 1'b0; rw_wb = 1'b0;
    rsrc = 2'b00; pcsrc = 1'b0; acc = 1'b0; ack = 1'b0;
  endtask

  // Inputs are already driven (after a negedge); compare, then advance one clock.
  task automatic step();
    bit stall_mem_wait, lu;
    bit [3:0] e_stall;
    bit [2:0] e_flush;
    bit e_req;
    #1;
    stall_mem_wait = m_failed || (m_waiting ? !ack : (acc && !ack));
    e_req = m_failed ? 1'b0 : (m_waiting ? 1'b1 : acc);
    lu = (rsrc == 2'b01) && (wa_ex != 5'd0) && (wa_ex == ra1_id || wa_ex == ra2_id);
    if (stall_mem_wait) begin
      e_stall = 4'b1111; e_flush = 3'b001;
    end else if (pcsrc) begin
      e_stall = 4'b0000; e_flush = 3'b110;
    end else if (lu) begin
      e_stall = 4'b1100; e_flush = 3'b010;
    end else begin
      e_stall = 4'b0000; e_flush = 3'b000;
    end
    check_val("stalls", 32'({s_if, s_id, s_ex, s_mem}), 32'(e_stall));
    check_val("flushes", 32'({f_id, f_ex, f_wb}), 32'(e_flush));
    check_val("memReq", 32'(mem_req), 32'(e_req));
    check_val("fwdA", 32'(fwd_a), 32'(ref_fwd(ra1_ex)));
    check_val("fwdB", 32'(fwd_b), 32'(ref_fwd(ra2_ex)));
    check_val("memError", 32'(mem_err), 32'(m_failed));
    check_val("stallCycles", 32'(stall_cnt), 32'(m_stalls));
    @(posedge clk);
    if (clr) begin
      m_waiting = 0; m_waited = 0; m_failed = 0; m_stalls = 0;
    end else begin
      if (e_stall[3]) m_stalls = (m_stalls == SAT) ? SAT : m_stalls + 1;
      if (!m_failed) begin
        if (m_waiting) begin
          if (ack) m_waiting = 0;
          else begin
            m_waited++;
            if (m_waited == TO) begin m_failed = 1; m_waiting = 0; end
          end
        end else if (acc && !ack) begin
          m_waiting = 1; m_waited = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    idle_inputs();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_waiting = 0; m_waited = 0; m_failed = 0; m_stalls = 0;
    clr = 1'b0;
    step();
    check_val("rst_cnt", 32'(stall_cnt), 32'd0);

    // load-use: lw x5 in EX, consumer reads x5
    rsrc = 2'b01; wa_ex = 5'd5; ra2_id = 5'd5;
    step();
    rsrc = 2'b00; wa_ex = 5'd0; ra2_id = 5'd0;
    step();
    check_val("lu_cnt", 32'(stall_cnt), 32'd1);
    rsrc = 2'b01; wa_ex = 5'd0; ra2_id = 5'd0;
    step();
    // branch beats load-use
    wa_ex = 5'd3; ra1_id = 5'd3; pcsrc = 1'b1;
    step();
    idle_inputs();
    // forwarding
    rw_mem = 1'b1; wa_mem = 5'd7; rw_wb = 1'b1; wa_wb = 5'd7; ra1_ex = 5'd7; ra2_ex = 5'd7;
    step();
    rw_mem = 1'b0;
    step();
    wa_wb = 5'd0; ra1_ex = 5'd0;
    step();
    idle_inputs();
    // memory wait with ack three cycles after the request, branch pending in EX
    acc = 1'b1; pcsrc = 1'b1;
    repeat (3) step();
    ack = 1'b1;
    step();
    ack = 1'b0; acc = 1'b0; pcsrc = 1'b0;
    step();
    // zero-wait access
    acc = 1'b1; ack = 1'b1;
    step();
    idle_inputs();
    // timeout
    acc = 1'b1;
    repeat (8) step();
    check_val("to_err", 32'(mem_err), 32'd1);
    check_val("to_req", 32'(mem_req), 32'd0);
    do_reset();
    step();
    check_val("clr_err", 32'(mem_err), 32'd0);
    check_val("clr_cnt", 32'(stall_cnt), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      clr    = ($urandom_range(0, 39) == 0);
      ra1_id = 5'($urandom_range(0, 3));
      ra2_id = 5'($urandom_range(0, 3));
      ra1_ex = 5'($urandom_range(0, 3));
      ra2_ex = 5'($urandom_range(0, 3));
      wa_ex  = 5'($urandom_range(0, 3));
      wa_mem = 5'($urandom_range(0, 3));
      wa_wb  = 5'($urandom_range(0, 3));
      rw_mem = 1'($urandom_range(0, 1));
      rw_wb  = 1'($urandom_range(0, 1));
      rsrc   = 2'($urandom_range(0, 3));
      pcsrc  = ($urandom_range(0, 3) == 0);
      acc    = ($urandom_range(0, 3) == 0);
      ack    = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
